// File: rtl/boot_pkg.sv
// Shared definitions for the PRAM boot-link responder family.
// Contents:
//   state_e          - responder FSM states
//   BYTES_PER_WORD   - stream bytes packed into one PRAM word
//   DEF_LAST_ADDR    - default first address past the boot image
//   DEF_TIMEOUT_CYC  - default idle-cycle budget between stream bytes
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ASSEMBLE = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_DONE     = 3'd3,
        ST_ABORT    = 3'd4
    } state_e;

    localparam int unsigned BYTES_PER_WORD  = 4;
    localparam logic [15:0] DEF_LAST_ADDR   = 16'h4000;
    localparam logic [23:0] DEF_TIMEOUT_CYC = 24'd1000000;

endpackage

// File: rtl/boot_word_responder_if.sv
// Signal bundle between the boot link / PRAM loader and the word responder.
// Handshake: a stream byte transfers on every rising i_clk edge where
// i_byte_valid and o_byte_ready are both high; the link keeps i_byte stable
// while i_byte_valid is high and the byte has not yet transferred.
// Ports (seen from the responder, modport slave):
//   i_ld_from_ext, i_addr_counter      - loader window and current address
//   i_byte_valid, i_byte, o_byte_ready - byte stream handshake
//   o_bus_ready                        - word committed, loader advances by 4
//   o_pram_we, o_pram_addr, o_pram_wdata - PRAM write port
//   o_interrupt, o_done                - stall abort / image complete
//   dbg_state                          - current FSM state, observation only
interface boot_word_responder_if #(
    parameter int unsigned ADDR_W = 16
) ();
    import boot_pkg::*;

    logic              i_ld_from_ext;
    logic [ADDR_W-1:0] i_addr_counter;
    logic              i_byte_valid;
    logic [7:0]        i_byte;
    logic              o_byte_ready;
    logic              o_bus_ready;
    logic              o_pram_we;
    logic [ADDR_W-1:0] o_pram_addr;
    logic [31:0]       o_pram_wdata;
    logic              o_interrupt;
    logic              o_done;
    state_e            dbg_state;

    modport master (
        output i_ld_from_ext, i_addr_counter, i_byte_valid, i_byte,
        input  o_byte_ready, o_bus_ready, o_pram_we, o_pram_addr,
               o_pram_wdata, o_interrupt, o_done, dbg_state
    );

    modport slave (
        input  i_ld_from_ext, i_addr_counter, i_byte_valid, i_byte,
        output o_byte_ready, o_bus_ready, o_pram_we, o_pram_addr,
               o_pram_wdata, o_interrupt, o_done, dbg_state
    );

endinterface

// File: rtl/boot_timeout_cnt.sv
// Idle-cycle counter for boot-link stall detection.
// Ports:
//   i_clk, i_a_reset_l - clock, asynchronous active-low reset
//   i_clr              - force the count to zero (has priority over i_en)
//   i_en               - advance the count by one
//   o_tc               - count currently equals TERM
module boot_timeout_cnt #(
    parameter int unsigned     TO_W = 24,
    parameter logic [TO_W-1:0] TERM = TO_W'(999999)
) (
    input  logic i_clk,
    input  logic i_a_reset_l,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_a_reset_l) begin
        if (!i_a_reset_l) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = (cnt_q == TERM);

endmodule

// File: rtl/boot_word_responder.sv
// Boot-link word responder: packs little-endian stream bytes into 32-bit
// words, writes each word into PRAM at the loader's address and pulses
// o_bus_ready so the loader steps on. A stalled stream raises o_interrupt;
// reaching LAST_ADDR raises o_done. Every output comes straight from a flop.
// Ports:
//   i_clk, i_a_reset_l - clock, asynchronous active-low reset
//   bus                - boot_word_responder_if.slave (stream, loader, PRAM)
module boot_word_responder
    import boot_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEF_LAST_ADDR),
    parameter int unsigned       TO_W        = 24,
    parameter logic [TO_W-1:0]   TIMEOUT_CYC = TO_W'(DEF_TIMEOUT_CYC)
) (
    input logic                  i_clk,
    input logic                  i_a_reset_l,
    boot_word_responder_if.slave bus
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES_PER_WORD);
    localparam logic [TO_W-1:0]   TO_TERM   = TIMEOUT_CYC - TO_W'(1);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;      // bytes 0..2; byte 3 goes straight to wdata
    logic              byte_ready_q, byte_ready_d;
    logic              bus_ready_q, bus_ready_d;
    logic              pram_we_q, pram_we_d;
    logic [ADDR_W-1:0] pram_addr_q, pram_addr_d;
    logic [31:0]       pram_wdata_q, pram_wdata_d;
    logic              interrupt_q, interrupt_d;
    logic              done_q, done_d;

    logic accept;
    logic to_clr;
    logic to_tc;

    assign accept = bus.i_byte_valid && byte_ready_q;

    // An accept on the terminal-count edge clears the counter and wins.
    assign to_clr = (state_q != ST_ASSEMBLE) || accept;

    boot_timeout_cnt #(
        .TO_W (TO_W),
        .TERM (TO_TERM)
    ) u_timeout (
        .i_clk       (i_clk),
        .i_a_reset_l (i_a_reset_l),
        .i_clr       (to_clr),
        .i_en        (!to_clr),
        .o_tc        (to_tc)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        word_d       = word_q;
        pram_addr_d  = pram_addr_q;
        pram_wdata_d = pram_wdata_q;

        case (state_q)
            ST_IDLE: begin
                idx_d = 2'd0;
                if (bus.i_ld_from_ext) begin
                    // Addresses at or past LAST_ADDR never reach a write.
                    if (bus.i_addr_counter >= LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ASSEMBLE;
                    end
                end
            end
            ST_ASSEMBLE: begin
                if (!bus.i_ld_from_ext) begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                end else if (accept) begin
                    case (idx_q)
                        2'd0: word_d[7:0]   = bus.i_byte;
                        2'd1: word_d[15:8]  = bus.i_byte;
                        2'd2: word_d[23:16] = bus.i_byte;
                        default: begin
                            // Last byte: capture address and word for the commit cycle.
                            pram_addr_d  = bus.i_addr_counter;
                            pram_wdata_d = {bus.i_byte, word_q};
                            state_d      = ST_COMMIT;
                        end
                    endcase
                    idx_d = idx_q + 2'd1;
                end else if (to_tc) begin
                    state_d = ST_ABORT;
                end
            end
            ST_COMMIT: begin
                // The write is presented during this cycle regardless of ld.
                idx_d = 2'd0;
                if (!bus.i_ld_from_ext) begin
                    state_d = ST_IDLE;
                end else if (bus.i_addr_counter + ADDR_STEP == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ASSEMBLE;
                end
            end
            ST_DONE: begin
                idx_d = 2'd0;
                if (!bus.i_ld_from_ext) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                idx_d = 2'd0;
                if (!bus.i_ld_from_ext) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase

        // Outputs are decoded from the next state so they are registered.
        byte_ready_d = (state_d == ST_ASSEMBLE);
        bus_ready_d  = (state_d == ST_COMMIT);
        pram_we_d    = (state_d == ST_COMMIT);
        interrupt_d  = (state_d == ST_ABORT);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_a_reset_l) begin
        if (!i_a_reset_l) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            bus_ready_q  <= 1'b0;
            pram_we_q    <= 1'b0;
            pram_addr_q  <= '0;
            pram_wdata_q <= '0;
            interrupt_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            bus_ready_q  <= bus_ready_d;
            pram_we_q    <= pram_we_d;
            pram_addr_q  <= pram_addr_d;
            pram_wdata_q <= pram_wdata_d;
            interrupt_q  <= interrupt_d;
            done_q       <= done_d;
        end
    end

    assign bus.o_byte_ready = byte_ready_q;
    assign bus.o_bus_ready  = bus_ready_q;
    assign bus.o_pram_we    = pram_we_q;
    assign bus.o_pram_addr  = pram_addr_q;
    assign bus.o_pram_wdata = pram_wdata_q;
    assign bus.o_interrupt  = interrupt_q;
    assign bus.o_done       = done_q;
    assign bus.dbg_state    = state_q;

endmodule
